// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and constants for the RV32M multiply/divide unit.
package mdu_pkg;
  localparam int XLEN = 32;
  localparam int ITER = XLEN;
  localparam int CNT_W = $clog2(ITER);
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;
  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h80000000;
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response bundle between the execute stage and the multiply/divide unit.
interface mul_div_unit_if;
  import mdu_pkg::*;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, funct3, opa, opb, flush, input busy, done, result);
  modport slave(input start, funct3, opa, opb, flush, output busy, done, result);
endinterface

// File: rtl/mdu_sign_ctrl.sv
// mdu_sign_ctrl: operand magnitudes, result-negate flag and special-case detection on the way in,
// sign restoration of the raw product/quotient/remainder on the way out.
module mdu_sign_ctrl
  import mdu_pkg::*;
(
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            neg_o,
  output logic            special_o,
  output logic [XLEN-1:0] special_res_o,
  input  md_op_e          post_op_i,
  input  logic            post_neg_i,
  input  logic [2*XLEN-1:0] raw_i,
  output logic [XLEN-1:0] res_o
);
  logic sa, sb, ovf, zero;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;
  always_comb begin
    sa = opa_i[XLEN-1] & (op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sb = opb_i[XLEN-1] & (op_i inside {MD_MULH, MD_DIV, MD_REM});
    mag_a_o = sa ? -opa_i : opa_i;
    mag_b_o = sb ? -opb_i : opb_i;
    neg_o = (op_i == MD_REM) ? sa : sa ^ sb;
    zero = opb_i == '0;
    ovf = (op_i inside {MD_DIV, MD_REM}) && opa_i == INT_MIN && opb_i == '1;
    special_o = op_i[2] & (zero | ovf);
    special_res_o = zero ? (op_i[1] ? opa_i : DIV_BY_ZERO_Q) : (op_i[1] ? '0 : INT_MIN);
    prod = post_neg_i ? -raw_i : raw_i;
    quo = post_neg_i ? -raw_i[XLEN-1:0] : raw_i[XLEN-1:0];
    rem = post_neg_i ? -raw_i[2*XLEN-1:XLEN] : raw_i[2*XLEN-1:XLEN];
    res_o = post_op_i[2] ? (post_op_i[1] ? rem : quo)
          : (post_op_i == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M unit; 32 shift-add or restoring-divide steps, single-cycle special cases.
module mul_div_unit
  import mdu_pkg::*;
(
  input logic clk,
  input logic rst,
  mul_div_unit_if.slave bus
);
  mdu_state_e state_q;
  md_op_e op_q;
  logic [CNT_W-1:0] cnt_q;
  logic neg_q, done_q;
  logic [XLEN-1:0] a_q, result_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0] sum, rem_sh;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] mag_a, mag_b, special_res, post_res;
  logic neg, special;
  mdu_sign_ctrl u_sign (
    .op_i(md_op_e'(bus.funct3)),
    .opa_i(bus.opa),
    .opb_i(bus.opb),
    .mag_a_o(mag_a),
    .mag_b_o(mag_b),
    .neg_o(neg),
    .special_o(special),
    .special_res_o(special_res),
    .post_op_i(op_q),
    .post_neg_i(neg_q),
    .raw_i(acc_d),
    .res_o(post_res)
  );
  // acc_q holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? a_q : {XLEN{1'b0}}};
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    diff = {1'b0, rem_sh} - {2'b0, a_q};
    acc_d = op_q[2] ? (diff[XLEN+1] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                    : {sum, acc_q[XLEN-1:1]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= MD_MUL;
      cnt_q <= '0;
      neg_q <= 1'b0;
      done_q <= 1'b0;
      a_q <= '0;
      acc_q <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start && !bus.flush) begin
          op_q <= md_op_e'(bus.funct3);
          neg_q <= neg;
          cnt_q <= '0;
          a_q <= bus.funct3[2] ? mag_b : mag_a;
          acc_q <= {{XLEN{1'b0}}, bus.funct3[2] ? mag_a : mag_b};
          if (special) begin
            result_q <= special_res;
            done_q <= 1'b1;
            state_q <= DONE;
          end else state_q <= CALC;
        end
        CALC: if (bus.flush) state_q <= IDLE;
        else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
            result_q <= post_res;
            done_q <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed RV32M vectors with a queue scoreboard checked by a done-driven monitor.
module tb_mul_div_unit;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mul_div_unit_if bus();
  mul_div_unit dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] exp;
    int lat;
    string nm;
    int st;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int errors = 0, checks = 0, cyc = 0, busy_run = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    busy_run = bus.busy ? busy_run + 1 : 0;
    if (bus.done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with result %h expected no done", bus.result);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, "_result"}, bus.result, e.exp);
        chk({e.nm, "_latency"}, 32'(cyc - e.st + 1), 32'(e.lat));
        chk({e.nm, "_busy_cycles"}, 32'(busy_run), 32'(e.lat));
      end
    end
  end
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string nm,
                       input bit push = 1'b1, input bit hold = 1'b0);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got busy %b expected 0", nm, bus.busy);
    end
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.opa = a;
    bus.opb = b;
    if (push) sbq.push_back('{exp, lat, nm, cyc + 1});
    @(posedge clk);
    if (hold) @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.funct3 = ~f;
    bus.opa = ~a;
    bus.opb = ~b;
  endtask
  initial begin
    int n;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = 3'b0;
    bus.opa = '0;
    bus.opb = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_result", bus.result, 0);
    rst = 1'b0;
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'b101;
    bus.opa = 32'd9;
    bus.opb = 32'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    issue(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    issue(3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, "mulhsu");
    issue(3'b000, 32'h12345678, 32'h10, 32'h23456780, 33, "mul_big");
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");
    issue(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");
    issue(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu");
    issue(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");
    issue(3'b100, 32'd1000, 32'd3, 32'd0, 33, "div_flushed", 1'b0);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bus.start = 1'b1;
    bus.funct3 = 3'b101;
    bus.opa = 32'd100;
    bus.opb = 32'd7;
    sbq.push_back('{32'd14, 33, "divu_after_flush", cyc + 1});
    @(negedge clk);
    chk("flush_busy", 32'(bus.busy), 0);
    chk("flush_done", 32'(bus.done), 0);
    chk("flush_result_kept", bus.result, 32'd2);
    @(posedge clk);
    #1 bus.start = 1'b0;
    issue(3'b101, 32'd55, 32'd0, 32'hFFFFFFFF, 1, "divu_by_zero", 1'b1, 1'b1);
    issue(3'b110, 32'd55, 32'd0, 32'd55, 1, "rem_by_zero");
    issue(3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1, "div_by_zero");
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_overflow");
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_overflow");
    issue(3'b000, 32'd3, 32'd5, 32'd15, 33, "mul_reset", 1'b0);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_busy", 32'(bus.busy), 0);
    chk("async_reset_done", 32'(bus.done), 0);
    chk("async_reset_result", bus.result, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33, "div_neg_divisor");
    issue(3'b110, 32'd100, 32'hFFFFFFF9, 32'd2, 33, "rem_neg_divisor");
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    chk("pending_results", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
